mem_line_arbiter: RTL and testbench
===================================

// Module: mem_line_arbiter
// PURPOSE
//  Arbitrates I-cache and D-cache line requests onto one shared 4-word-line memory port.
//  Latches the winning request, line-aligns the address, holds the memory strobes for LATENCY
//  cycles, captures the read line, and pulses done to the winner.
//  Sits between the cache controllers and the line memory.
// PARAMETERS
//  ADDR_W   16  word-address width
//  WORD_W   16  word width; one line = 4*WORD_W bits, word0 in LSBs
//  LATENCY  2   cycles the memory needs per line access; legal range 1..15
// PORTS
//  clk        in   1         clock; all logic on posedge
//  reset      in   1         synchronous, active-high reset
//  i_req      in   1         I-side line read request (level)
//  i_addr     in   ADDR_W    I-side word address
//  i_done     out  1         1-cycle pulse: I line valid on rdata
//  d_req      in   1         D-side request (level)
//  d_we       in   1         D-side op: 1 = line write, 0 = line read
//  d_addr     in   ADDR_W    D-side word address
//  d_wdata    in   4*WORD_W  D-side write line
//  d_done     out  1         1-cycle pulse: D read data valid, or D write committed
//  rdata      out  4*WORD_W  captured read line, shared by both sides
//  busy       out  1         high whenever state != IDLE
//  mem_read   out  1         memory line-read strobe
//  mem_write  out  1         memory line-write strobe
//  mem_addr   out  ADDR_W    line-aligned address: {addr[ADDR_W-1:2],2'b00}
//  mem_wdata  out  4*WORD_W  write line to memory
//  mem_rdata  in   4*WORD_W  read line from memory, valid in the last BUSY cycle
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high.
//  Reset: state=IDLE, cnt=0; all outputs 0, including rdata and mem_wdata; last-grant=I.
//   Reset mid-transaction aborts it. No done pulse is issued; the strobes drop the next cycle.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE
//   - If any req is high, pick a winner.
//   - Latch side, op, line-aligned addr and wdata.
//   - Load cnt=LATENCY-1 and go to BUSY.
//  BUSY
//   - mem_read=!op_we or mem_write=op_we, held for exactly LATENCY cycles.
//   - mem_addr and mem_wdata are stable for the whole window.
//   - When cnt==0: on a read, rdata<=mem_rdata; go to RESP. Otherwise decrement cnt.
//  RESP
//   - Strobes low. Winner's done=1 for exactly this cycle, then return to IDLE.
//   - rdata holds until the next read capture. A write leaves rdata unchanged.
//  Timing: a req first seen high in IDLE cycle 0 gives
//   - strobes high in cycles 1..LATENCY;
//   - done in cycle LATENCY+1;
//   - next possible grant in cycle LATENCY+2.
//  Handshake
//   - A requester holds req and its operands stable until its done.
//   - It drops req the cycle after done, unless it wants a new transaction.
//   - Dropping req mid-transaction does not cancel it; done still pulses.
//   - Operand changes after the grant are ignored.
//  Arbitration with both reqs high in IDLE: D wins (fixed priority).
//  i_done and d_done are never high together; at most one transaction is in flight.
//  Addresses with low bits != 0 are aligned by masking; no error is raised.
// CONFIGURATION
//  MEM_ARB_RR_EN defined
//   - Round-robin: on a tie, the side NOT granted last wins.
//   - Last-grant updates on each grant.
//   - A continuously requesting side waits at most one transaction.
//  MEM_ARB_RR_EN undefined
//   - Fixed D-over-I priority; a permanently asserted d_req starves I.
//   - No last-grant register is built.
// TESTING  (LATENCY=2 unless noted)
//  1. Assert reset for 2 cycles, then release -> every output is 0 and busy=0.
//  2. i_req, i_addr=16'h0025, mem returns 64'h0004_0003_0002_0001 ->
//     mem_read in cycles 1-2 with mem_addr=16'h0024; i_done in cycle 3;
//     rdata=64'h0004_0003_0002_0001.
//  3. d_req, d_we=1, d_addr=16'h00B3, d_wdata=64'hDEAD_BEEF_CAFE_F00D ->
//     mem_write in cycles 1-2 with mem_addr=16'h00B0 and that wdata; d_done in cycle 3;
//     rdata unchanged.
//  4. i_req and d_req raised in the same cycle -> D served first (d_done in cycle 3);
//     I granted in cycle 4, i_done in cycle 7.
//  5. MEM_ARB_RR_EN defined, both reqs held high for 4 transactions ->
//     grants alternate D,I,D,I.
//     MEM_ARB_RR_EN undefined -> grants are D,D,D,D.
//  6. Reset asserted in cycle 2 of an I read -> no i_done; strobes 0 from cycle 3;
//     a new request after release completes normally.
//  7. LATENCY=1 and LATENCY=15 -> strobes last exactly 1 and 15 cycles; done follows at +1.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// -----------------------------------------------------------------------------
// mem_line_arbiter
//
// Arbitrates I-cache and D-cache line requests onto a single shared memory
// port that moves 4-word lines. A winning request is latched (side, op,
// line-aligned address, write line). The memory strobe is then held for
// LATENCY cycles and a read line is captured from the memory. Finally a
// one-cycle done pulse goes back to the winning side.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin on a tie (the side not granted last wins)
//   undefined -> fixed D-over-I priority, no last-grant register
//
// Parameters
//   ADDR_W   word-address width
//   WORD_W   word width; a line is 4*WORD_W bits, word0 in the LSBs
//   LATENCY  memory cycles per line access, 1..15
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   i_req, i_addr     I-side line read request and word address
//   i_done            1-cycle pulse: I read line valid on rdata
//   d_req, d_we       D-side request and op (1 = line write, 0 = line read)
//   d_addr, d_wdata   D-side word address and write line
//   d_done            1-cycle pulse: D read valid or D write committed
//   rdata             last captured read line, shared by both sides
//   busy              high whenever a transaction is in progress
//   mem_read/write    memory strobes, held for LATENCY cycles
//   mem_addr          line-aligned address to memory
//   mem_wdata         write line to memory
//   mem_rdata         read line from memory, valid in the last strobe cycle
// -----------------------------------------------------------------------------
module mem_line_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int WORD_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [4*WORD_W-1:0] d_wdata,
    output logic                d_done,
    output logic [4*WORD_W-1:0] rdata,
    output logic                busy,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [4*WORD_W-1:0] mem_wdata,
    input  logic [4*WORD_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [3:0]        CNT_LOAD  = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                side_is_d_q;     // 1: D side owns the transaction
    logic                op_we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [4*WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0]   rdata_q [4];

    logic                grant;
    logic                win_d;
    logic                capture;
    logic [ADDR_W-1:0]   win_addr;

    // ---------------------------------------------------------------- arbiter
`ifdef MEM_ARB_RR_EN
    logic last_d_q;   // 1: the most recent grant went to D

    // On a tie the side that was not granted last wins.
    assign win_d = d_req & (~i_req | ~last_d_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else if (grant) begin
            last_d_q <= win_d;
        end
    end
`else
    assign win_d = d_req;
`endif

    assign grant    = (state_q == ST_IDLE) && (i_req || d_req);
    assign win_addr = (win_d ? d_addr : i_addr) & LINE_MASK;
    // Read capture happens on the final strobe cycle only.
    assign capture  = (state_q == ST_BUSY) && (cnt_q == 4'd0) && !op_we_q;

    // ----------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        i_done    = 1'b0;
        d_done    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_BUSY: begin
                mem_read  = !op_we_q;
                mem_write = op_we_q;
            end
            ST_RESP: begin
                i_done = !side_is_d_q;
                d_done = side_is_d_q;
            end
            default: busy = 1'b0;
        endcase
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            side_is_d_q <= 1'b0;
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            for (int w = 0; w < 4; w++) begin
                rdata_q[w] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (grant) begin
                side_is_d_q <= win_d;
                op_we_q     <= win_d & d_we;
                addr_q      <= win_addr;
                // An I grant leaves the previous write line on mem_wdata.
                if (win_d) begin
                    wdata_q <= d_wdata;
                end
            end
            if (capture) begin
                for (int w = 0; w < 4; w++) begin
                    rdata_q[w] <= mem_rdata[w*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_lane
            assign rdata[gi*WORD_W +: WORD_W] = rdata_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mem_line_arbiter.sv
module tb_mem_line_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_done;
    logic [63:0] rdata;
    logic        busy;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_line_arbiter #(.ADDR_W(16), .WORD_W(16), .LATENCY(LAT)) dut (
        .clk(clk), .reset(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .rdata(rdata), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Extra instances for the latency extremes (index 0: LATENCY=1, 1: 15).
    logic        x_i_req [2];
    logic [63:0] x_rd = 64'h1111_2222_3333_4444;
    logic        x_i_done [2];
    logic        x_d_done [2];
    logic        x_busy [2];
    logic        x_mem_read [2];
    logic        x_mem_write [2];
    logic [15:0] x_mem_addr [2];
    logic [63:0] x_rdata [2];
    logic [63:0] x_mem_wdata [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lat
            initial x_i_req[gi] = 1'b0;
            mem_line_arbiter #(.ADDR_W(16), .WORD_W(16), .LATENCY(gi == 0 ? 1 : 15)) u_x (
                .clk(clk), .reset(rst),
                .i_req(x_i_req[gi]), .i_addr(16'h0107), .i_done(x_i_done[gi]),
                .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(64'h0),
                .d_done(x_d_done[gi]), .rdata(x_rdata[gi]), .busy(x_busy[gi]),
                .mem_read(x_mem_read[gi]), .mem_write(x_mem_write[gi]),
                .mem_addr(x_mem_addr[gi]), .mem_wdata(x_mem_wdata[gi]),
                .mem_rdata(x_rd)
            );
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the arbiter should remember between transactions.
    bit          m_last_d;
    logic [63:0] m_rdata;
    // Requester-side state: pending requests with operands held until done.
    bit          pend_i, pend_d;
    logic [15:0] p_i_addr, p_d_addr;
    bit          p_d_we;
    logic [63:0] p_d_wdata;
    bit          force_rd;
    logic [63:0] forced_rd;
    bit          obs_d_done;
    int          txn_no = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last_d = 1'b0;
        m_rdata  = '0;
        pend_i   = 1'b0;
        pend_d   = 1'b0;
    endtask

    // One arbitration round, starting in a cycle where the DUT must be idle.
    task automatic do_round();
        bit          win_d, e_we;
        logic [15:0] e_addr;
        logic [63:0] cap;
        check_eq("idle_busy", {63'd0, busy}, 64'd0);
        check_eq("idle_done", {62'd0, i_done, d_done}, 64'd0);
        i_req   = pend_i;  i_addr = p_i_addr;
        d_req   = pend_d;  d_we   = p_d_we;
        d_addr  = p_d_addr; d_wdata = p_d_wdata;
        if (!pend_i && !pend_d) begin
            tick();
            return;
        end
`ifdef MEM_ARB_RR_EN
        win_d = pend_d && (!pend_i || !m_last_d);
`else
        win_d = pend_d;
`endif
        e_we   = win_d && p_d_we;
        e_addr = (win_d ? p_d_addr : p_i_addr) & 16'hFFFC;
        cap    = '0;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check_eq("busy_strobe", {62'd0, mem_read, mem_write}, {62'd0, !e_we, e_we});
            check_eq("busy_addr", {48'd0, mem_addr}, {48'd0, e_addr});
            if (e_we) check_eq("busy_wdata", mem_wdata, p_d_wdata);
            check_eq("busy_flag", {63'd0, busy}, 64'd1);
            check_eq("busy_done", {62'd0, i_done, d_done}, 64'd0);
            mem_rdata = force_rd ? forced_rd : {$urandom, $urandom};
            if (c == LAT) cap = mem_rdata;
            if (c == 1) begin
                // Operand churn and req drop after the grant must be ignored.
                if (win_d) begin
                    d_addr = 16'($urandom); d_wdata = {$urandom, $urandom};
                    d_we = 1'($urandom); d_req = 1'($urandom);
                end else begin
                    i_addr = 16'($urandom); i_req = 1'($urandom);
                end
            end
        end
        tick();
        obs_d_done = d_done;
        check_eq("resp_done", {62'd0, i_done, d_done}, {62'd0, !win_d, win_d});
        check_eq("resp_strobe", {62'd0, mem_read, mem_write}, 64'd0);
        if (!e_we) m_rdata = cap;
        check_eq("resp_rdata", rdata, m_rdata);
        $display("txn %0d side=%s we=%0d addr=%h rdata=%h", txn_no, win_d ? "D" : "I",
                 e_we, e_addr, rdata);
        txn_no++;
        m_last_d = win_d;
        if (win_d) begin pend_d = 1'b0; d_req = 1'b0; end
        else       begin pend_i = 1'b0; i_req = 1'b0; end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes, done_cyc, lat_x;
        force_rd = 1'b0;
        forced_rd = '0;
        p_i_addr = '0; p_d_addr = '0; p_d_we = 1'b0; p_d_wdata = '0;
        model_reset();
        tick();

        // Reset state: every output zero.
        do_reset();
        check_eq("rst_ctrl", {57'd0, busy, mem_read, mem_write, i_done, d_done, 2'b00}, 64'd0);
        check_eq("rst_addr", {48'd0, mem_addr}, 64'd0);
        check_eq("rst_wdata", mem_wdata, 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);

        // Directed I read with unaligned address.
        force_rd = 1'b1; forced_rd = 64'h0004_0003_0002_0001;
        pend_i = 1'b1; p_i_addr = 16'h0025;
        do_round();
        check_eq("dir_iread", rdata, 64'h0004_0003_0002_0001);

        // Directed D write: rdata must be left alone.
        pend_d = 1'b1; p_d_we = 1'b1; p_d_addr = 16'h00B3; p_d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        do_round();
        check_eq("dir_dwrite_rdata", rdata, 64'h0004_0003_0002_0001);
        force_rd = 1'b0;

        // Both requesters held high over four transactions.
        do_reset();
        pend_i = 1'b1; p_i_addr = 16'h0040;
        pend_d = 1'b1; p_d_we = 1'b0; p_d_addr = 16'h0081;
        for (int k = 0; k < 4; k++) begin
            do_round();
`ifdef MEM_ARB_RR_EN
            check_eq("tie_seq", {63'd0, obs_d_done}, {63'd0, (k % 2) == 0});
`else
            check_eq("tie_seq", {63'd0, obs_d_done}, 64'd1);
`endif
            pend_i = 1'b1; pend_d = 1'b1;
        end
        pend_i = 1'b0; pend_d = 1'b0;
        tick();

        // Reset landing in the second strobe cycle of an I read.
        do_reset();
        i_req = 1'b1; i_addr = 16'h0013;
        tick();                       // cycle 1
        tick();                       // cycle 2
        rst = 1'b1;
        tick();                       // cycle 3
        check_eq("abort_ctrl", {59'd0, busy, mem_read, mem_write, i_done, d_done}, 64'd0);
        rst = 1'b0; i_req = 1'b0;
        model_reset();
        tick();
        check_eq("abort_nodone", {62'd0, i_done, d_done}, 64'd0);
        check_eq("abort_rdata", rdata, 64'd0);
        pend_i = 1'b1; p_i_addr = 16'h0200;
        do_round();

        // Randomized traffic honouring the requester handshake.
        for (int n = 0; n < 150; n++) begin
            if (!pend_i && $urandom_range(9) < 6) begin
                pend_i = 1'b1; p_i_addr = 16'($urandom);
            end
            if (!pend_d && $urandom_range(9) < 6) begin
                pend_d = 1'b1; p_d_addr = 16'($urandom);
                p_d_we = 1'($urandom); p_d_wdata = {$urandom, $urandom};
            end
            do_round();
        end

        // Latency extremes on the extra instances.
        for (int j = 0; j < 2; j++) begin
            lat_x = (j == 0) ? 1 : 15;
            strobes = 0;
            done_cyc = 0;
            x_i_req[j] = 1'b1;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                tick();
                x_i_req[j] = 1'b0;
                if (x_mem_read[j]) strobes++;
                if (x_i_done[j]) begin
                    done_cyc = cyc;
                    check_eq("lat_rdata", x_rdata[j], x_rd);
                    check_eq("lat_addr", {48'd0, x_mem_addr[j]}, 64'h0104);
                    check_eq("lat_misc", {61'd0, x_busy[j], x_d_done[j], x_mem_write[j]}, 64'd4);
                    check_eq("lat_wdata", x_mem_wdata[j], 64'd0);
                    break;
                end
            end
            check_eq("lat_strobes", 64'(strobes), 64'(lat_x));
            check_eq("lat_done_cyc", 64'(done_cyc), 64'(lat_x + 1));
            $display("txn latency=%0d strobes=%0d done_cycle=%0d", lat_x, strobes, done_cyc);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
